// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types, constants and helpers for the cascaded BCD
//                counter (digit type, lap display state, load clamp).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  // Display source: live count or the captured lap value
  typedef enum logic [0:0] {
    LIVE = 1'b0,
    HELD = 1'b1
  } lap_state_t;

  // Loaded nibbles above 9 saturate to 9 so a digit never leaves BCD range
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit cell. Steps up (9 -> 0) or down (0 -> 9) when
//                step is high, parallel-loads a clamped nibble on load, and
//                flags 9 / 0 for the carry/borrow chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n,
  input  logic       step,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] ld_digit,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == 4'd0);

  // Next digit value: load has priority over a step
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(ld_digit);
    end else if (step) begin
      if (up_dn) begin
        digit_d = at_max ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_d = at_min ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  // Digit register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_chain_counter.sv
// ============================================================================
//  Module      : bcd_chain_counter
//  Description : DIGITS-digit cascaded BCD up/down counter with a prescaler,
//                parallel load, wrap flag and optional lap-hold display.
//                Optional feature macro: BCD_CHAIN_COUNTER_LAP_EN
//                (defined: lap hold register + LIVE/HELD state machine;
//                 undefined: disp is wired straight to count).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_chain_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] disp,
  output logic                tick,
  output logic                wrap
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre_q;
  logic [PRE_W-1:0]  pre_d;
  logic              tick_q;
  logic              wrap_q;
  logic              w_pre_hit;
  logic              w_step;
  logic [DIGITS:0]   w_chain;
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_min;

  // A step coincident with load is discarded rather than deferred
  assign w_pre_hit = (pre_q == PRE_LAST);
  assign w_step    = en & w_pre_hit & ~load;

  // Prescaler: free-runs while enabled, holds when paused, restarts on load
  always_comb begin
    pre_d = pre_q;
    if (load) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = w_pre_hit ? '0 : pre_q + 1'b1;
    end
  end

  // Prescaler and step/wrap pulse registers
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= w_step;
      wrap_q <= w_chain[DIGITS];
    end
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

  // Ripple enable: a digit steps only when every lower digit is at its
  // rollover value for the current direction; the last link is the wrap.
  assign w_chain[0] = w_step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_chain[g+1] = w_chain[g] & (up_dn ? w_at_max[g] : w_at_min[g]);

    bcd_digit u_digit (
      .clk      (clk),
      .clear_n  (clear_n),
      .step     (w_chain[g]),
      .up_dn    (up_dn),
      .load     (load),
      .ld_digit (load_val[4*g +: 4]),
      .digit    (count[4*g +: 4]),
      .at_max   (w_at_max[g]),
      .at_min   (w_at_min[g])
    );
  end

`ifdef BCD_CHAIN_COUNTER_LAP_EN
  lap_state_t          lap_q;
  lap_state_t          lap_d;
  logic [4*DIGITS-1:0] hold_q;
  logic [4*DIGITS-1:0] hold_d;

  // Lap next state: load forces LIVE; lap toggles, capturing on entry to HELD
  always_comb begin
    lap_d  = lap_q;
    hold_d = hold_q;
    if (load) begin
      lap_d = LIVE;
    end else if (lap) begin
      if (lap_q == LIVE) begin
        lap_d  = HELD;
        hold_d = count;
      end else begin
        lap_d = LIVE;
      end
    end
  end

  // Lap state and hold register
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      lap_q  <= LIVE;
      hold_q <= '0;
    end else begin
      lap_q  <= lap_d;
      hold_q <= hold_d;
    end
  end

  assign disp = (lap_q == HELD) ? hold_q : count;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign disp         = count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_chain_counter.sv
// ============================================================================
//  Module      : tb_bcd_chain_counter
//  Description : Self-checking bench for bcd_chain_counter. Two instances
//                share stimulus: one steps every cycle, one every 5 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_chain_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clear_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic         lap;
  logic [W-1:0] load_val;
  logic [W-1:0] count_a, disp_a, count_b, disp_b;
  logic         tick_a, wrap_a, tick_b, wrap_b;

  bcd_chain_counter #(.DIGITS(DIGITS), .TICK_DIV(1)) u_dut_a (
    .clk(clk), .clear_n(clear_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .lap(lap), .count(count_a), .disp(disp_a),
    .tick(tick_a), .wrap(wrap_a)
  );

  bcd_chain_counter #(.DIGITS(DIGITS), .TICK_DIV(5)) u_dut_b (
    .clk(clk), .clear_n(clear_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .lap(lap), .count(count_b), .disp(disp_b),
    .tick(tick_b), .wrap(wrap_b)
  );

`ifdef BCD_CHAIN_COUNTER_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  typedef struct {
    string        tag;
    bit           dut_b;
    logic [W-1:0] cnt;
    logic [W-1:0] dsp;
    logic         tck;
    logic         wrp;
  } exp_t;

  typedef struct {
    logic [W-1:0] ld;
    bit           up;
    logic [W-1:0] exp_ld;
    logic [W-1:0] exp_step;
    bit           exp_wrap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input string tag, input bit b, input logic [W-1:0] c,
                            input logic [W-1:0] d, input logic t, input logic w);
    exp_t e;
    e.tag = tag; e.dut_b = b; e.cnt = c; e.dsp = d; e.tck = t; e.wrp = w;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t         e;
    logic [W-1:0] ac, ad;
    logic         at, aw;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ac = e.dut_b ? count_b : count_a;
      ad = e.dut_b ? disp_b  : disp_a;
      at = e.dut_b ? tick_b  : tick_a;
      aw = e.dut_b ? wrap_b  : wrap_a;
      checks++;
      if ({ac, ad, at, aw} !== {e.cnt, e.dsp, e.tck, e.wrp}) begin
        errors++;
        $display("FAIL %s (dut_%s): got count=%h disp=%h tick=%b wrap=%b, expected count=%h disp=%h tick=%b wrap=%b",
                 e.tag, e.dut_b ? "b" : "a", ac, ad, at, aw, e.cnt, e.dsp, e.tck, e.wrp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    compare();
  endtask

  // Reference BCD step: digit-wise ripple with carry/borrow out as wrap
  task automatic bcd_step(input logic [W-1:0] v, input bit up,
                          output logic [W-1:0] n, output bit w);
    logic [3:0] d;
    bit         c;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end
      end
      n[4*i +: 4] = d;
    end
    w = c;
  endtask

  initial begin
    logic [W-1:0] nxt;
    bit           nw;

    vecs[0] = '{16'h0999, 1'b1, 16'h0999, 16'h1000, 1'b0};
    vecs[1] = '{16'h9999, 1'b1, 16'h9999, 16'h0000, 1'b1};
    vecs[2] = '{16'h1000, 1'b0, 16'h1000, 16'h0999, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 16'h0000, 16'h9999, 1'b1};
    vecs[4] = '{16'hA3F5, 1'b1, 16'h9395, 16'h9396, 1'b0};
    vecs[5] = '{16'h0129, 1'b1, 16'h0129, 16'h0130, 1'b0};
    vecs[6] = '{16'h5550, 1'b0, 16'h5550, 16'h5549, 1'b0};
    vecs[7] = '{16'hFFFF, 1'b0, 16'h9999, 16'h9998, 1'b0};

    clear_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; lap = 1'b0; load_val = '0;

    // Reset held two cycles with en=1
    @(posedge clk); #1;
    expect_out("reset_a", 0, 16'h0, 16'h0, 0, 0);
    expect_out("reset_b", 1, 16'h0, 16'h0, 0, 0);
    cycle();

    // First tick on dut_b arrives on the 5th edge after release
    clear_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_out("holdoff_b", 1, 16'h0, 16'h0, 0, 0);
      cycle();
    end
    expect_out("first_tick_b", 1, 16'h0001, 16'h0001, 1, 0);
    cycle();

    // Advance to pre=2, then pause for 7 cycles
    for (int k = 0; k < 2; k++) begin
      expect_out("pre_adv_b", 1, 16'h0001, 16'h0001, 0, 0);
      cycle();
    end
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      expect_out("paused_b", 1, 16'h0001, 16'h0001, 0, 0);
      cycle();
    end
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_out("resume_b", 1, 16'h0001, 16'h0001, 0, 0);
      cycle();
    end
    expect_out("resume_tick_b", 1, 16'h0002, 16'h0002, 1, 0);
    cycle();

    // Load with coincident step: clamp, no tick, prescaler restarts
    for (int k = 0; k < 4; k++) begin
      expect_out("pre_to_last_b", 1, 16'h0002, 16'h0002, 0, 0);
      cycle();
    end
    load = 1'b1; load_val = 16'hA3F5;
    expect_out("load_clamp_b", 1, 16'h9395, 16'h9395, 0, 0);
    cycle();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_out("post_load_b", 1, 16'h9395, 16'h9395, 0, 0);
      cycle();
    end
    expect_out("post_load_tick_b", 1, 16'h9396, 16'h9396, 1, 0);
    cycle();

    // Table: load, one step, then one more step from the model
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; load_val = vecs[i].ld; up_dn = vecs[i].up; en = 1'b1;
      expect_out("tbl_load", 0, vecs[i].exp_ld, vecs[i].exp_ld, 0, 0);
      cycle();
      load = 1'b0;
      expect_out("tbl_step", 0, vecs[i].exp_step, vecs[i].exp_step, 1, vecs[i].exp_wrap);
      cycle();
      bcd_step(vecs[i].exp_step, vecs[i].up, nxt, nw);
      expect_out("tbl_next", 0, nxt, nxt, 1, nw);
      cycle();
    end

    // Lap sequence on dut_a
    en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 16'h0120;
    expect_out("lap_load", 0, 16'h0120, 16'h0120, 0, 0);
    cycle();
    load = 1'b0; en = 1'b1;
    expect_out("lap_run", 0, 16'h0121, 16'h0121, 1, 0); cycle();
    expect_out("lap_run", 0, 16'h0122, 16'h0122, 1, 0); cycle();
    expect_out("lap_run", 0, 16'h0123, 16'h0123, 1, 0); cycle();
    lap = 1'b1;
    expect_out("lap_capture", 0, 16'h0124, LAP_ON ? 16'h0123 : 16'h0124, 1, 0);
    cycle();
    lap = 1'b0;
    expect_out("lap_held", 0, 16'h0125, LAP_ON ? 16'h0123 : 16'h0125, 1, 0); cycle();
    expect_out("lap_held", 0, 16'h0126, LAP_ON ? 16'h0123 : 16'h0126, 1, 0); cycle();
    expect_out("lap_held", 0, 16'h0127, LAP_ON ? 16'h0123 : 16'h0127, 1, 0); cycle();
    lap = 1'b1;
    expect_out("lap_release", 0, 16'h0128, 16'h0128, 1, 0);
    cycle();
    expect_out("lap_recapture", 0, 16'h0129, LAP_ON ? 16'h0128 : 16'h0129, 1, 0);
    cycle();
    lap = 1'b0; load = 1'b1; load_val = 16'h0500;
    expect_out("load_forces_live", 0, 16'h0500, 16'h0500, 0, 0);
    cycle();
    lap = 1'b1; load_val = 16'h0600;
    expect_out("load_beats_lap", 0, 16'h0600, 16'h0600, 0, 0);
    cycle();
    lap = 1'b0; load = 1'b0;
    expect_out("live_after_load", 0, 16'h0601, 16'h0601, 1, 0);
    cycle();

    // Mid-operation reset while the display is held
    lap = 1'b1;
    expect_out("hold_before_reset", 0, 16'h0602, LAP_ON ? 16'h0601 : 16'h0602, 1, 0);
    cycle();
    lap = 1'b0; clear_n = 1'b0;
    expect_out("midrst_a", 0, 16'h0, 16'h0, 0, 0);
    expect_out("midrst_b", 1, 16'h0, 16'h0, 0, 0);
    cycle();
    clear_n = 1'b1;
    expect_out("post_rst_a", 0, 16'h0001, 16'h0001, 1, 0);
    expect_out("post_rst_b", 1, 16'h0000, 16'h0000, 0, 0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
